// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - shared RV32M op codes, FSM states and width default
package muldiv_unit_pkg;

    localparam int DEFAULT_XLEN = 32;

    localparam logic [4:0] ALU_MUL    = 5'b01000;
    localparam logic [4:0] ALU_MULH   = 5'b01001;
    localparam logic [4:0] ALU_MULHU  = 5'b01010;
    localparam logic [4:0] ALU_MULHSU = 5'b01011;
    localparam logic [4:0] ALU_DIV    = 5'b01100;
    localparam logic [4:0] ALU_DIVU   = 5'b01101;
    localparam logic [4:0] ALU_REM    = 5'b01110;
    localparam logic [4:0] ALU_REMU   = 5'b01111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PREP   = 2'd1,
        CALC   = 2'd2,
        FINISH = 2'd3
    } state_t;

    function automatic logic is_m_op(input logic [4:0] sel);
        return sel[4:3] == 2'b01;
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// rtl/muldiv_datapath.sv - shared shift-add / restoring shift-subtract iteration engine
module muldiv_datapath #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic              is_div,
    input  logic [XLEN-1:0]   a_mag,
    input  logic [XLEN-1:0]   b_mag,
    output logic [2*XLEN-1:0] acc,
    output logic              last
);

    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN:0]     lhs;
    logic [XLEN:0]     rhs;
    logic [XLEN+1:0]   sum;
    logic [2*XLEN-1:0] acc_next;

    // One adder serves both ops: multiply adds the multiplicand into the upper half,
    // divide subtracts the divisor (carry-out set means the partial remainder >= divisor).
    always_comb begin
        lhs      = is_div ? acc[2*XLEN-1:XLEN-1] : {1'b0, acc[2*XLEN-1:XLEN]};
        rhs      = is_div ? ~{1'b0, b_q} : (acc[0] ? {1'b0, a_q} : '0);
        sum      = {1'b0, lhs} + {1'b0, rhs} + {{(XLEN+1){1'b0}}, is_div};
        acc_next = acc;
        if (is_div) begin
            if (sum[XLEN+1])
                acc_next = {sum[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            else
                acc_next = {lhs[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end else begin
            acc_next = {sum[XLEN:0], acc[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            acc <= '0;
            cnt <= '0;
        end else if (load) begin
            a_q <= a_mag;
            b_q <= b_mag;
            acc <= is_div ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
            cnt <= '0;
        end else if (step) begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
        end
    end

    assign last = (cnt == CNT_W'(XLEN - 1));

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit with issue/kill handshake
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN  = DEFAULT_XLEN,
    parameter int CNT_W = 6
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic [4:0]      SELECT,
    input  logic [XLEN-1:0] DATA1,
    input  logic [XLEN-1:0] DATA2,
    input  logic            KILL,
    output logic            BUSY,
    output logic            DONE,
    output logic [XLEN-1:0] RESULT
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state, state_next;
    logic [4:0]        op_q;
    logic [XLEN-1:0]   d1_q, d2_q;
    logic              neg_q, special_q;
    logic [XLEN-1:0]   special_val_q;
    logic              done_q;
    logic [XLEN-1:0]   result_q;

    logic              accept, load, step, last;
    logic              is_div, want_rem, signed_a, signed_b, a_neg, b_neg;
    logic              res_neg, div_zero, overflow, special;
    logic [XLEN-1:0]   a_mag, b_mag, special_val, fin_val;
    logic [XLEN-1:0]   q_fix, r_fix;
    logic [2*XLEN-1:0] acc, prod_fix;

    assign accept = (state == IDLE) && START && !KILL && is_m_op(SELECT);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        BUSY       = (state != IDLE);
        case (state)
            IDLE:   if (accept) state_next = PREP;
            PREP: begin
                load       = 1'b1;
                state_next = special ? FINISH : CALC;
            end
            CALC: begin
                step = 1'b1;
                if (last) state_next = FINISH;
            end
            FINISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (KILL && state != IDLE) state_next = IDLE;
    end

    // Operand decode on the latched op; magnitudes feed the unsigned engine.
    always_comb begin
        is_div      = op_q[2];
        want_rem    = op_q[2] & op_q[1];
        signed_a    = (op_q == ALU_MULH) || (op_q == ALU_MULHSU) ||
                      (op_q == ALU_DIV)  || (op_q == ALU_REM);
        signed_b    = (op_q == ALU_MULH) || (op_q == ALU_DIV) || (op_q == ALU_REM);
        a_neg       = signed_a & d1_q[XLEN-1];
        b_neg       = signed_b & d2_q[XLEN-1];
        a_mag       = a_neg ? -d1_q : d1_q;
        b_mag       = b_neg ? -d2_q : d2_q;
        res_neg     = want_rem ? a_neg : (a_neg ^ b_neg);
        div_zero    = is_div && (d2_q == '0);
        overflow    = is_div && signed_b && (d1_q == INT_MIN) && (d2_q == '1);
        special     = div_zero || overflow;
        special_val = div_zero ? (want_rem ? d1_q : '1) : (want_rem ? '0 : d1_q);
    end

    always_comb begin
        prod_fix = neg_q ? -acc : acc;
        q_fix    = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        r_fix    = neg_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        fin_val  = '0;
        case (op_q)
            ALU_MUL:                          fin_val = prod_fix[XLEN-1:0];
            ALU_MULH, ALU_MULHU, ALU_MULHSU:  fin_val = prod_fix[2*XLEN-1:XLEN];
            ALU_DIV, ALU_DIVU:                fin_val = q_fix;
            ALU_REM, ALU_REMU:                fin_val = r_fix;
            default:                          fin_val = '0;
        endcase
        if (special_q) fin_val = special_val_q;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            op_q          <= '0;
            d1_q          <= '0;
            d2_q          <= '0;
            neg_q         <= 1'b0;
            special_q     <= 1'b0;
            special_val_q <= '0;
            done_q        <= 1'b0;
            result_q      <= '0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                op_q <= SELECT;
                d1_q <= DATA1;
                d2_q <= DATA2;
            end
            if (state == PREP) begin
                neg_q         <= res_neg;
                special_q     <= special;
                special_val_q <= special_val;
            end
            if (state == FINISH && !KILL) begin
                result_q <= fin_val;
                done_q   <= 1'b1;
            end
        end
    end

    muldiv_datapath #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_datapath (
        .clk    (CLK),
        .rst    (RESET),
        .load   (load),
        .step   (step),
        .is_div (is_div),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .acc    (acc),
        .last   (last)
    );

    assign DONE   = done_q;
    assign RESULT = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit against an arithmetic reference
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        START = 1'b0;
    logic [4:0]  SELECT = '0;
    logic [31:0] DATA1 = '0;
    logic [31:0] DATA2 = '0;
    logic        KILL = 1'b0;
    logic        BUSY;
    logic        DONE;
    logic [31:0] RESULT;

    int errors = 0;
    int checks = 0;

    muldiv_unit dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .START  (START),
        .SELECT (SELECT),
        .DATA1  (DATA1),
        .DATA2  (DATA2),
        .KILL   (KILL),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .RESULT (RESULT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] ref_result(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, sp;
        logic [63:0]        up;
        logic signed [31:0] sa32, sb32, sr;
        sa   = {{32{a[31]}}, a};
        sb   = {{32{b[31]}}, b};
        sa32 = a;
        sb32 = b;
        up   = {32'b0, a} * {32'b0, b};
        case (sel)
            ALU_MUL:    return up[31:0];
            ALU_MULHU:  return up[63:32];
            ALU_MULH: begin
                sp = sa * sb;
                return sp[63:32];
            end
            ALU_MULHSU: begin
                sp = sa * $signed({32'b0, b});
                return sp[63:32];
            end
            ALU_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                sr = sa32 / sb32;
                return sr;
            end
            ALU_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                sr = sa32 % sb32;
                return sr;
            end
            ALU_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            ALU_REMU:   return (b == 0) ? a : a % b;
            default:    return 32'h0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
        if (sel[2] && b == 0) return 2;
        if ((sel == ALU_DIV || sel == ALU_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return 34;
    endfunction

    // Drive a request, let it be sampled, then scramble the operand inputs.
    task automatic issue(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
        START  = 1'b1;
        SELECT = sel;
        DATA1  = a;
        DATA2  = b;
        @(posedge CLK);
        #1;
        START  = 1'b0;
        SELECT = 5'($urandom);
        DATA1  = $urandom;
        DATA2  = $urandom;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge CLK);
            #1;
            if (DONE) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        @(negedge CLK);
        issue(sel, a, b);
        wait_done(lat);
        res = RESULT;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", BUSY); end
        checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", DONE); end
        checks++; if (RESULT !== 32'h0) begin errors++; $display("FAIL reset_result got %h expected 00000000", RESULT); end
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_mul_basic();
        int lat;
        @(negedge CLK);
        issue(ALU_MUL, 32'd25, 32'd20);
        checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL mul_busy_after_accept got %b expected 1", BUSY); end
        wait_done(lat);
        checks++; if (lat != 34) begin errors++; $display("FAIL mul_latency got %0d expected 34", lat); end
        checks++; if (RESULT !== 32'h0000_01F4) begin errors++; $display("FAIL mul_result got %h expected 000001f4", RESULT); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL mul_busy_in_done got %b expected 0", BUSY); end
        @(posedge CLK);
        #1;
        checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL mul_done_width got %b expected 0", DONE); end
        checks++; if (RESULT !== 32'h0000_01F4) begin errors++; $display("FAIL mul_result_hold got %h expected 000001f4", RESULT); end
    endtask

    task automatic test_directed();
        logic [4:0]  sel_t [8] = '{ALU_MULH, ALU_MULHU, ALU_MULHSU, ALU_MUL,
                                   ALU_DIV, ALU_REM, ALU_DIVU, ALU_REMU};
        logic [31:0] a_t   [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                   32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
        logic [31:0] exp_t [8] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
                                   32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC, 32'h0000_0001};
        logic [31:0] res;
        int lat;
        for (int i = 0; i < 8; i++) begin
            run_op(sel_t[i], a_t[i], 32'd2, res, lat);
            checks++; if (res !== exp_t[i]) begin errors++; $display("FAIL directed_%0d sel=%b got %h expected %h", i, sel_t[i], res, exp_t[i]); end
            checks++; if (lat != 34) begin errors++; $display("FAIL directed_lat_%0d got %0d expected 34", i, lat); end
        end
    endtask

    task automatic test_special();
        logic [4:0]  sel_t [4] = '{ALU_DIV, ALU_REMU, ALU_DIV, ALU_REM};
        logic [31:0] a_t   [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] b_t   [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp_t [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};
        logic [31:0] res;
        int lat;
        for (int i = 0; i < 4; i++) begin
            run_op(sel_t[i], a_t[i], b_t[i], res, lat);
            checks++; if (res !== exp_t[i]) begin errors++; $display("FAIL special_%0d got %h expected %h", i, res, exp_t[i]); end
            checks++; if (lat != 2) begin errors++; $display("FAIL special_lat_%0d got %0d expected 2", i, lat); end
        end
    endtask

    task automatic test_random();
        logic [4:0]  sel;
        logic [31:0] a, b, res;
        int lat, mode;
        for (int i = 0; i < 40; i++) begin
            sel  = ALU_MUL + 5'($urandom_range(0, 7));
            mode = $urandom_range(0, 9);
            a    = $urandom;
            b    = $urandom;
            if (mode == 0) b = 32'h0;
            else if (mode == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (mode == 2) begin a = 32'($urandom_range(0, 300)) - 32'd150; b = 32'($urandom_range(1, 20)); end
            else if (mode == 3) b = 32'hFFFF_FFFF;
            run_op(sel, a, b, res, lat);
            checks++; if (res !== ref_result(sel, a, b)) begin errors++; $display("FAIL random_%0d sel=%b a=%h b=%h got %h expected %h", i, sel, a, b, res, ref_result(sel, a, b)); end
            checks++; if (lat != ref_latency(sel, a, b)) begin errors++; $display("FAIL random_lat_%0d got %0d expected %0d", i, lat, ref_latency(sel, a, b)); end
        end
    endtask

    task automatic test_busy_start();
        logic [31:0] a, b;
        int lat, stray;
        a = 32'h0012_3456;
        b = 32'h0000_0789;
        @(negedge CLK);
        issue(ALU_MUL, a, b);
        for (int k = 0; k < 5; k++) begin
            @(posedge CLK);
            #1;
            START  = 1'b1;
            SELECT = ALU_DIVU;
            DATA1  = $urandom;
            DATA2  = $urandom;
        end
        START = 1'b0;
        wait_done(lat);
        checks++; if (RESULT !== ref_result(ALU_MUL, a, b)) begin errors++; $display("FAIL busy_start_result got %h expected %h", RESULT, ref_result(ALU_MUL, a, b)); end
        checks++; if (lat + 5 != 34) begin errors++; $display("FAIL busy_start_latency got %0d expected 34", lat + 5); end
        stray = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge CLK);
            #1;
            if (BUSY || DONE) stray++;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL busy_start_ignored got %0d busy/done cycles expected 0", stray); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        int lat;
        run_op(ALU_MULHU, 32'hDEAD_BEEF, 32'h1234_5678, res, lat);
        checks++; if (res !== ref_result(ALU_MULHU, 32'hDEAD_BEEF, 32'h1234_5678)) begin errors++; $display("FAIL b2b_first got %h expected %h", res, ref_result(ALU_MULHU, 32'hDEAD_BEEF, 32'h1234_5678)); end
        issue(ALU_REM, 32'hFFFF_FF00, 32'd7);
        checks++; if (BUSY !== 1'b1 || DONE !== 1'b0) begin errors++; $display("FAIL b2b_accept got busy=%b done=%b expected busy=1 done=0", BUSY, DONE); end
        wait_done(lat);
        checks++; if (RESULT !== ref_result(ALU_REM, 32'hFFFF_FF00, 32'd7)) begin errors++; $display("FAIL b2b_second got %h expected %h", RESULT, ref_result(ALU_REM, 32'hFFFF_FF00, 32'd7)); end
        checks++; if (lat != 34) begin errors++; $display("FAIL b2b_latency got %0d expected 34", lat); end
    endtask

    task automatic test_bad_select();
        int stray;
        @(negedge CLK);
        START  = 1'b1;
        SELECT = 5'b00000;
        DATA1  = 32'd3;
        DATA2  = 32'd4;
        @(posedge CLK);
        #1;
        START = 1'b0;
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL bad_select_busy got %b expected 0", BUSY); end
        @(negedge CLK);
        START  = 1'b1;
        SELECT = ALU_MUL;
        KILL   = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        KILL  = 1'b0;
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL kill_start_idle_busy got %b expected 0", BUSY); end
        stray = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge CLK);
            #1;
            if (DONE) stray++;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL ignored_start_done got %0d pulses expected 0", stray); end
    endtask

    task automatic test_kill();
        logic [31:0] res;
        int lat, stray;
        run_op(ALU_MUL, 32'd7, 32'd6, res, lat);
        checks++; if (res !== 32'd42) begin errors++; $display("FAIL kill_setup got %h expected 0000002a", res); end
        @(negedge CLK);
        issue(ALU_DIV, 32'h1234_5678, 32'd3);
        repeat (9) @(posedge CLK);
        #1;
        KILL = 1'b1;
        @(posedge CLK);
        #1;
        KILL = 1'b0;
        checks++; if (BUSY !== 1'b0 || DONE !== 1'b0) begin errors++; $display("FAIL kill_idle got busy=%b done=%b expected 0 0", BUSY, DONE); end
        stray = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge CLK);
            #1;
            if (DONE) stray++;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL kill_no_done got %0d pulses expected 0", stray); end
        checks++; if (RESULT !== 32'd42) begin errors++; $display("FAIL kill_result_hold got %h expected 0000002a", RESULT); end
        run_op(ALU_DIVU, 32'd100, 32'd7, res, lat);
        checks++; if (res !== 32'd14 || lat != 34) begin errors++; $display("FAIL kill_restart got %h lat %0d expected 0000000e lat 34", res, lat); end
    endtask

    task automatic test_reset_abort();
        int stray;
        @(negedge CLK);
        issue(ALU_DIV, 32'h7654_3210, 32'd9);
        repeat (9) @(posedge CLK);
        #2;
        RESET = 1'b1;
        #1;
        checks++; if (BUSY !== 1'b0 || DONE !== 1'b0) begin errors++; $display("FAIL reset_abort_ctrl got busy=%b done=%b expected 0 0", BUSY, DONE); end
        checks++; if (RESULT !== 32'h0) begin errors++; $display("FAIL reset_abort_result got %h expected 00000000", RESULT); end
        @(negedge CLK);
        RESET = 1'b0;
        stray = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge CLK);
            #1;
            if (DONE || BUSY) stray++;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL reset_abort_quiet got %0d active cycles expected 0", stray); end
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_directed();
        test_special();
        test_random();
        test_busy_start();
        test_back_to_back();
        test_bad_select();
        test_kill();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
